// File: rtl/cache_ctrl_fsm.sv
// Sequencing controller for a 2-way set-associative L1 cache: lookup, LRU upkeep,
// write-through and miss refill toward L2/RAM, plus saturating hit/miss statistics.
module cache_ctrl_fsm #(
    parameter int addr_width = 16,
    parameter int data_width = 32,
    parameter int idx_size   = 6,
    parameter int block_no   = 64,
    parameter int cnt_width  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cpu_req_i,
    input  logic                  cpu_we_i,
    input  logic [addr_width-1:0] cpu_addr_i,
    input  logic [data_width-1:0] cpu_wdata_i,
    output logic [data_width-1:0] cpu_rdata_o,
    output logic                  cpu_ready_o,
    output logic                  busy_o,
    output logic [idx_size-1:0]   idx_o,
    input  logic                  hit_s1_i,
    input  logic                  hit_s2_i,
    input  logic                  valid_out_s1_i,
    input  logic                  valid_out_s2_i,
    input  logic [data_width-1:0] rdata_s1_i,
    input  logic [data_width-1:0] rdata_s2_i,
    output logic                  we_s1_o,
    output logic                  we_s2_o,
    output logic [data_width-1:0] fill_data_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [addr_width-1:0] mem_addr_o,
    output logic [data_width-1:0] mem_wdata_o,
    input  logic                  mem_ack_i,
    input  logic [data_width-1:0] mem_rdata_i,
    output logic [cnt_width-1:0]  hit_cnt_o,
    output logic [cnt_width-1:0]  miss_cnt_o,
    output logic                  err_o
);

    // state   | meaning
    // IDLE    | waiting for cpu_req_i
    // LOOKUP  | evaluate hit/valid for the latched index
    // MEM_WR  | write-through request, wait for ack
    // MEM_RD  | refill read request, wait for ack
    // FILL    | write refill data into the victim set
    // RESPOND | one-cycle cpu_ready_o pulse
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LOOKUP  = 3'd1;
    localparam logic [2:0] S_MEM_WR  = 3'd2;
    localparam logic [2:0] S_MEM_RD  = 3'd3;
    localparam logic [2:0] S_FILL    = 3'd4;
    localparam logic [2:0] S_RESPOND = 3'd5;

    logic [2:0]            state_q, state_d;
    logic [addr_width-1:0] addr_q, addr_d;
    logic                  we_q, we_d;
    logic [data_width-1:0] wdata_q, wdata_d;
    logic [data_width-1:0] rdata_q, rdata_d;
    logic [data_width-1:0] fill_q, fill_d;
    logic                  victim_q, victim_d;
    logic [block_no-1:0]   lru_q, lru_d;
    logic [cnt_width-1:0]  hit_cnt_q, hit_cnt_d;
    logic [cnt_width-1:0]  miss_cnt_q, miss_cnt_d;
    logic                  err_q, err_d;

    logic [idx_size-1:0]   idx;
    logic                  hit_any;

    assign idx     = addr_q[idx_size-1:0];
    assign hit_any = hit_s1_i | hit_s2_i;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        fill_d     = fill_q;
        victim_d   = victim_q;
        lru_d      = lru_q;
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        err_d      = err_q;

        case (state_q)
            S_IDLE: begin
                if (cpu_req_i) begin
                    addr_d  = cpu_addr_i;
                    we_d    = cpu_we_i;
                    wdata_d = cpu_wdata_i;
                    state_d = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (hit_any) begin
                    // a double hit is resolved as set 1 and flagged
                    if (hit_s1_i && hit_s2_i) err_d = 1'b1;
                    lru_d[idx] = ~hit_s1_i;
                    if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + cnt_width'(1);
                    if (we_q) begin
                        state_d = S_MEM_WR;
                    end else begin
                        rdata_d = hit_s1_i ? rdata_s1_i : rdata_s2_i;
                        state_d = S_RESPOND;
                    end
                end else begin
                    if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + cnt_width'(1);
                    if (we_q) begin
                        state_d = S_MEM_WR;
                    end else begin
                        // victim encoding: 0 = set 1, 1 = set 2
                        if (!valid_out_s1_i)      victim_d = 1'b0;
                        else if (!valid_out_s2_i) victim_d = 1'b1;
                        else                      victim_d = ~lru_q[idx];
                        state_d = S_MEM_RD;
                    end
                end
            end
            S_MEM_WR: begin
                if (mem_ack_i) state_d = S_RESPOND;
            end
            S_MEM_RD: begin
                if (mem_ack_i) begin
                    fill_d  = mem_rdata_i;
                    rdata_d = mem_rdata_i;
                    state_d = S_FILL;
                end
            end
            S_FILL: begin
                lru_d[idx] = victim_q;
                state_d    = S_RESPOND;
            end
            S_RESPOND: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        we_s1_o = 1'b0;
        we_s2_o = 1'b0;
        if (state_q == S_LOOKUP && we_q) begin
            we_s1_o = hit_s1_i;
            we_s2_o = hit_s2_i & ~hit_s1_i;
        end else if (state_q == S_FILL) begin
            we_s1_o = ~victim_q;
            we_s2_o = victim_q;
        end
    end

    assign fill_data_o = (state_q == S_LOOKUP) ? wdata_q : fill_q;
    assign cpu_rdata_o = rdata_q;
    assign cpu_ready_o = (state_q == S_RESPOND);
    assign busy_o      = (state_q != S_IDLE);
    assign idx_o       = idx;
    assign mem_req_o   = (state_q == S_MEM_WR) || (state_q == S_MEM_RD);
    assign mem_we_o    = (state_q == S_MEM_WR);
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign hit_cnt_o   = hit_cnt_q;
    assign miss_cnt_o  = miss_cnt_q;
    assign err_o       = err_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            fill_q     <= '0;
            victim_q   <= 1'b0;
            lru_q      <= '0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            fill_q     <= fill_d;
            victim_q   <= victim_d;
            lru_q      <= lru_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
            err_q      <= err_d;
        end
    end

endmodule
